// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and opcode classification shared by the sequential ALU
package alu_pkg;
  typedef enum logic [3:0] {
    OP_AND    = 4'b0000,
    OP_OR     = 4'b0001,
    OP_ADD    = 4'b0010,
    OP_SLL    = 4'b0011,
    OP_SUB    = 4'b0100,
    OP_SRL    = 4'b0101,
    OP_MUL    = 4'b0110,
    OP_XOR    = 4'b0111,
    OP_SLTU   = 4'b1000,
    OP_SLT    = 4'b1001,
    OP_SRA    = 4'b1010,
    OP_PASS_B = 4'b1011,
    OP_DIVU   = 4'b1100,
    OP_REMU   = 4'b1101,
    OP_PASS_E = 4'b1110,
    OP_PASS_F = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_e;

  function automatic logic is_multicycle(alu_op_e op);
    return op inside {OP_MUL, OP_DIVU, OP_REMU};
  endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring unsigned divider
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  // acc: product accumulator or partial remainder; x: multiplicand or dividend/quotient; y: multiplier or divisor
  logic [WIDTH-1:0] acc, x, y, acc_nxt, x_nxt, y_nxt;
  logic [WIDTH:0]   r_sh;
  logic             ge, active;
  logic [CW-1:0]    cnt;
  alu_op_e          op_q;
  // one iteration step; result is the value after the current step so the final step can be captured directly
  always_comb begin
    r_sh    = {acc, x[WIDTH-1]};
    ge      = r_sh >= {1'b0, y};
    acc_nxt = op_q == OP_MUL ? acc + (y[0] ? x : '0) : ge ? r_sh[WIDTH-1:0] - y : r_sh[WIDTH-1:0];
    x_nxt   = op_q == OP_MUL ? x << 1 : {x[WIDTH-2:0], ge};
    y_nxt   = op_q == OP_MUL ? y >> 1 : y;
    result  = op_q == OP_DIVU ? x_nxt : acc_nxt;
  end
  assign done = active && cnt == '0;
  // load operands on start, then step once per cycle for WIDTH cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      x      <= '0;
      y      <= '0;
      cnt    <= '0;
      active <= 1'b0;
      op_q   <= OP_AND;
    end else if (start) begin
      acc    <= '0;
      x      <= a;
      y      <= b;
      cnt    <= CW'(WIDTH - 1);
      active <= 1'b1;
      op_q   <= op;
    end else if (active) begin
      acc    <= acc_nxt;
      x      <= x_nxt;
      y      <= y_nxt;
      cnt    <= cnt - 1'b1;
      active <= cnt != '0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute ALU with registered results and iterative mul/div
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             busy
);
  alu_state_e         state, state_nxt;
  alu_op_e            op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sc_result, md_result;
  logic               md_done, accept;
  assign op        = alu_op_e'(alu_control);
  assign shamt     = rs2_data[SHAMT_W-1:0];
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state == BUSY;
  assign accept    = in_valid && in_ready && !kill;
  // single-cycle datapath
  always_comb begin
    case (op)
      OP_AND:  sc_result = rs1_data & rs2_data;
      OP_OR:   sc_result = rs1_data | rs2_data;
      OP_ADD:  sc_result = rs1_data + rs2_data;
      OP_SUB:  sc_result = rs1_data - rs2_data;
      OP_XOR:  sc_result = rs1_data ^ rs2_data;
      OP_SLL:  sc_result = rs1_data << shamt;
      OP_SRL:  sc_result = rs1_data >> shamt;
      OP_SRA:  sc_result = WIDTH'($signed(rs1_data) >>> shamt);
      OP_SLTU: sc_result = WIDTH'(rs1_data < rs2_data);
      OP_SLT:  sc_result = WIDTH'($signed(rs1_data) < $signed(rs2_data));
      default: sc_result = rs1_data;
    endcase
  end
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && is_multicycle(op)),
    .op     (op),
    .a      (rs1_data),
    .b      (rs2_data),
    .done   (md_done),
    .result (md_result)
  );
  // next state; kill overrides everything, including a same-cycle request
  always_comb begin
    state_nxt = kill ? IDLE :
                state == IDLE ? (in_valid ? (is_multicycle(op) ? BUSY : DONE) : IDLE) :
                state == BUSY ? (md_done ? DONE : BUSY) :
                (out_ready ? IDLE : DONE);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end
  // result and zero flag are captured only on entry to DONE and held until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result <= '0;
      zero       <= 1'b1;
    end else if (accept && !is_multicycle(op)) begin
      alu_result <= sc_result;
      zero       <= sc_result == '0;
    end else if (state == BUSY && md_done && !kill) begin
      alu_result <= md_result;
      zero       <= md_result == '0;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven, random and corner-sequence checks of alu_seq against a behavioural model
module tb_alu_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, kill = 1'b0, out_ready = 1'b1;
  logic [3:0]  alu_control = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic        in_ready, out_valid, zero, busy;
  logic [31:0] alu_result;
  int          errors = 0, checks = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, exp;
  } vec_t;
  vec_t tbl[17];

  // behavioural reference: plain arithmetic on the opcode meaning
  function automatic logic [31:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    int unsigned sh;
    sh = b % 32;
    p  = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd4:  return a - b;
      4'd7:  return a ^ b;
      4'd3:  return a << sh;
      4'd5:  return a >> sh;
      4'd10: return $signed(a) >>> sh;
      4'd8:  return a < b ? 32'd1 : 32'd0;
      4'd9:  return $signed(a) < $signed(b) ? 32'd1 : 32'd0;
      4'd6:  return p[31:0];
      4'd12: return b == 0 ? 32'hFFFF_FFFF : a / b;
      4'd13: return b == 0 ? a : a % b;
      default: return a;
    endcase
  endfunction

  function automatic int exp_lat(logic [3:0] op);
    return (op == 4'd6 || op == 4'd12 || op == 4'd13) ? 33 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // wait (bounded) until the block is idle, sampling at the falling edge
  task automatic idle();
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // issue one operation and return the first presented result and its latency in cycles
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic z, output int lat);
    idle();
    in_valid = 1'b1; alu_control = op; rs1_data = a; rs2_data = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = alu_result;
    z = zero;
  endtask

  initial begin
    logic [31:0] r, a, b, held;
    logic        z, seen;
    logic [3:0]  op;
    int          lat;
    tbl[0]  = '{4'h2, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0004};
    tbl[1]  = '{4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    tbl[2]  = '{4'h8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    tbl[3]  = '{4'hA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000};
    tbl[4]  = '{4'h6, 32'h0001_0003, 32'h0000_0010, 32'h0010_0030};
    tbl[5]  = '{4'hC, 32'd100,       32'd7,         32'd14};
    tbl[6]  = '{4'hD, 32'd100,       32'd7,         32'd2};
    tbl[7]  = '{4'hC, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF};
    tbl[8]  = '{4'hD, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234};
    tbl[9]  = '{4'h4, 32'd7,         32'd7,         32'd0};
    tbl[10] = '{4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    tbl[11] = '{4'h1, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF};
    tbl[12] = '{4'h7, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00};
    tbl[13] = '{4'h3, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
    tbl[14] = '{4'h5, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
    tbl[15] = '{4'hB, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF};
    tbl[16] = '{4'h6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", alu_result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, r, z, lat);
      check($sformatf("vec%0d_result", i), r, tbl[i].exp);
      check($sformatf("vec%0d_zero", i), 32'(z), 32'(tbl[i].exp == 0));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(tbl[i].op)));
    end

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      do_op(op, a, b, r, z, lat);
      check($sformatf("rnd%0d_op%0h_result", i, op), r, model(op, a, b));
      check($sformatf("rnd%0d_op%0h_latency", i, op), 32'(lat), 32'(exp_lat(op)));
    end

    idle();
    out_ready = 1'b0;
    do_op(4'h6, 32'h0000_1234, 32'h0000_0100, r, z, lat);
    check("hold_first", r, 32'h0012_3400);
    held = r;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_result", alu_result, held);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);

    idle();
    in_valid = 1'b1; alu_control = 4'hC; rs1_data = 32'd1000; rs2_data = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("div_busy", 32'(busy), 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_in_ready", 32'(in_ready), 32'd1);
    check("kill_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("kill_no_out_valid", 32'(seen), 32'd0);

    @(negedge clk);
    kill = 1'b1; in_valid = 1'b1; alu_control = 4'h2; rs1_data = 32'd1; rs2_data = 32'd1;
    @(posedge clk); #1;
    kill = 1'b0; in_valid = 1'b0;
    check("kill_prio_out_valid", 32'(out_valid), 32'd0);
    check("kill_prio_in_ready", 32'(in_ready), 32'd1);

    idle();
    in_valid = 1'b1; alu_control = 4'h6; rs1_data = 32'd9; rs2_data = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_result", alu_result, 32'd0);
    check("midrst_zero", 32'(zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'h2, 32'd40, 32'd2, r, z, lat);
    check("post_rst_add", r, 32'd42);
    check("post_rst_latency", 32'(lat), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("post_rst_no_stale_mul", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
